fanout_capture_serializer: RTL

FANOUT_CAPTURE_SERIALIZER -- requirements
Module: fanout_capture_serializer

---
 rtl/fanout_capture_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/fanout_capture_serializer.sv
// rtl/fanout_capture_serializer.sv - capture fanned-out copies, check agreement, serialize LSB first
module fanout_capture_serializer #(
    parameter int WIDTH = 20,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] lines,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CW-1:0]    ones_count
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mm_q, mm_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic [CW-1:0]    pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CW'(lines[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mm_d    = mm_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    sreg_d  = lines;
                    bcnt_d  = '0;
                    ones_d  = pop;
                    // copies disagree unless every copy read the same value
                    mm_d    = (pop != '0) && (pop != CW'(WIDTH));
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (valid_q && ser_ready) begin
                    sreg_d = sreg_q >> 1;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(WIDTH - 1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mm_q    <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mm_q    <= mm_d;
            ones_q  <= ones_d;
        end
    end

    assign ser_data   = sreg_q[0];
    assign ser_valid  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign mismatch   = mm_q;
    assign ones_count = ones_q;

endmodule
